serial_mouse_tx: RTL and testbench
==================================

// Module: serial_mouse_tx
// PURPOSE
//  Device end of the Microsoft serial-mouse link. This is the block the PC-side 8250 UART talks to.
//  It accumulates relative motion and button state from a local pointer source.
//  It serialises 3-byte MS packets onto a 1200-baud 7N1 line and answers an RTS rising edge with ident 'M'.
//  It sits between the pointer decoder and the COM1 8250 receive pin.
// PARAMETERS
//  CLK_FREQ    10_000_000  iClk frequency, Hz
//  BAUD        1200        line rate; bit period = CLK_FREQ/BAUD cycles, rounded down
//  IDENT_DLY   CLK_FREQ/100  cycles from RTS rise to ident start (10 ms)
// PORTS
//  iClk        in   1  system clock
//  iRstN       in   1  reset: asynchronous assert, active-low
//  iMoveValid  in   1  one-cycle strobe; iDx/iDy/buttons valid
//  iDx         in   9  signed X delta, +right
//  iDy         in   9  signed Y delta, +down (caller converts)
//  iBtnL       in   1  left button, 1=pressed
//  iBtnR       in   1  right button
//  iBtnM       in   1  middle button (used only with wheel/3-btn option)
//  iRts        in   1  8250 RTS, synchronous to iClk; 0 = mouse unpowered
//  oTx         out  1  serial line to 8250 RX, idle 1
//  oBusy       out  1  frame or ident in flight
// BEHAVIOUR
//  Reset: oTx=1, oBusy=0, accumulators=0, latched buttons=0, FSM=OFF.
//  Reset deassertion is synchronised internally. Reset mid-frame aborts the frame immediately.
//  FSM states: OFF, IDENT_WAIT, IDLE, SEND.
//  - OFF: entered whenever iRts=0, from any state, in the same cycle.
//    In OFF: oTx=1, accumulators cleared, all moves ignored.
//  - OFF -> IDENT_WAIT on iRts 0->1 edge. The edge is detected with one register delay.
//  - IDENT_WAIT: counts IDENT_DLY cycles, then queues ident bytes and moves to SEND.
//  - IDLE -> SEND when accX!=0, accY!=0, or buttons differ from last sent.
//    On that cycle the packet is latched and the accumulators are cleared.
//  - SEND -> IDLE after the last stop bit of the last queued byte.
//  - Motion accumulates in IDLE, SEND and IDENT_WAIT.
//  Accumulators:
//  - Signed 10-bit sum, saturated to [-128,+127] each move.
//  - A move arriving on the latch cycle is not lost: acc <= sat(0 + in).
//  Packet (7-bit bytes):
//  - b0 = 1,L,R,Y7,Y6,X7,X6
//  - b1 = 0,X5..X0
//  - b2 = 0,Y5..Y0
//  Frame: start 0, 7 data LSB first, stop 1. Bit period = CLK_FREQ/BAUD cycles.
//  Bytes are back-to-back with no gap. Byte order is b0, b1, b2.
//  Buttons are sampled at latch time, so changes during SEND go to the next packet.
//  oBusy=1 from the cycle after latch until the final stop bit completes.
// CONFIGURATION
//  `SERIAL_MOUSE_3BTN_EN defined (Logitech 3-button mode):
//  - ident is 'M','3' (0x4D, 0x33);
//  - a 4th byte 0x20 (M pressed) or 0x00 is appended whenever iBtnM changed since the last packet;
//  - an M change alone also triggers a packet.
//  Undefined: ident is 'M' only, iBtnM is ignored, always 3 bytes.
// STRUCTURE
//  Shared header serialMouse.vh:
//  - ident byte constants;
//  - packet bit positions (SYNC=6, L=5, R=4);
//  - state encodings;
//  - MAX_BYTES = 4.
//  Sub-module serial_mouse_shifter: 7N1 bit serialiser with baud counter.
//  - interface: iStart/iData[6:0]/oTx/oDone;
//  - the FSM feeds it one byte at a time from a small byte queue.
//  Saturating accumulator: inline function, no sub-module.
// TESTING (CLK_FREQ=10e6, bit=8333 cycles)
//  1 RTS 0->1 -> oTx idle 10 ms, then frame 0x4D: start, 1,0,1,1,0,0,1, stop. oBusy spans 9 bits.
//  2 After ident, move dx=+5 dy=-3, L=1 -> bytes 0x6C, 0x05, 0x3D, back-to-back, 27 bit times.
//  3 Two moves dx=+100 each during SEND -> next packet X=127: b0[1:0]=01, b1=0x3F. Y=0 gives b2=0x00.
//  4 Move on the exact latch cycle -> appears intact in the following packet; no delta lost.
//  5 RTS dropped mid-b1 -> oTx=1 the next cycle; no further bits until RTS rises, then a fresh ident.
//  6 3BTN_EN: ident bytes 0x4D, 0x33. Press M alone -> 0x40, 0x00, 0x00, 0x20.
//    Without the macro the same stimulus sends nothing.

Source files
------------

// File: rtl/serial_mouse_tx_pkg.sv
// serial_mouse_tx_pkg
// Shared constants for the Microsoft serial-mouse transmitter:
//   - ident byte values ('M' and the Logitech '3' suffix)
//   - header-byte bit positions (SYNC=6, L=5, R=4)
//   - FSM state encodings (exported on the top-level oState debug port)
//   - MAX_BYTES, the depth of the per-packet byte queue
//   - satAdd(): saturating accumulator step
//   - headerByte(): builds packet byte 0 from buttons and delta high bits
// Optional feature macro used by the importing files: SERIAL_MOUSE_3BTN_EN
package serial_mouse_tx_pkg;

    localparam logic [6:0] IDENT_M     = 7'h4D;
    localparam logic [6:0] IDENT_3     = 7'h33;
    localparam logic [6:0] BYTE_M_DOWN = 7'h20;
    localparam logic [6:0] BYTE_M_UP   = 7'h00;

    localparam int PKT_SYNC = 6;
    localparam int PKT_L    = 5;
    localparam int PKT_R    = 4;

    localparam int MAX_BYTES = 4;

    localparam logic [1:0] ST_OFF        = 2'd0;
    localparam logic [1:0] ST_IDENT_WAIT = 2'd1;
    localparam logic [1:0] ST_IDLE       = 2'd2;
    localparam logic [1:0] ST_SEND       = 2'd3;

    // Add a 9-bit signed delta to an 8-bit signed accumulator, clamping
    // the 10-bit signed sum to the range a packet can carry.
    function automatic logic signed [7:0] satAdd(input logic signed [7:0] acc,
                                                 input logic signed [8:0] delta);
        logic signed [9:0] sum;
        sum = $signed({{2{acc[7]}}, acc}) + $signed({delta[8], delta});
        if (sum > 10'sd127) begin
            return 8'sd127;
        end else if (sum < -10'sd128) begin
            return -8'sd128;
        end else begin
            return sum[7:0];
        end
    endfunction

    // Byte 0: 1, L, R, Y7, Y6, X7, X6
    function automatic logic [6:0] headerByte(input logic       btnL,
                                              input logic       btnR,
                                              input logic [1:0] yHi,
                                              input logic [1:0] xHi);
        logic [6:0] b;
        b           = '0;
        b[PKT_SYNC] = 1'b1;
        b[PKT_L]    = btnL;
        b[PKT_R]    = btnR;
        b[3:2]      = yHi;
        b[1:0]      = xHi;
        return b;
    endfunction

endpackage

// File: rtl/serial_mouse_tx_shifter.sv
// serial_mouse_tx_shifter
// 7N1 serialiser with its own baud counter: start bit 0, seven data bits
// LSB first, stop bit 1, each bit BIT_CYCLES clocks long.
// Ports:
//   iClk, iRstN   clock, asynchronous active-low reset
//   iAbort        drop any frame in flight; line returns to 1 next cycle
//   iStart        load iData and begin a frame (accepted when idle or on oDone)
//   iData[6:0]    byte to send
//   oTx           serial line, idle 1
//   oDone         one-cycle pulse on the last clock of the stop bit
//   oBusy         frame in flight
// Handshake: iStart is honoured whenever oBusy=0 or oDone=1; a start on the
// oDone cycle makes the next start bit follow the stop bit with no gap.
module serial_mouse_tx_shifter #(
    parameter int BIT_CYCLES = 8333
) (
    input  logic       iClk,
    input  logic       iRstN,
    input  logic       iAbort,
    input  logic       iStart,
    input  logic [6:0] iData,
    output logic       oTx,
    output logic       oDone,
    output logic       oBusy
);

    localparam int CW = $clog2(BIT_CYCLES + 1);

    logic [8:0]    shReg;
    logic [CW-1:0] baudCnt;
    logic [3:0]    bitIdx;
    logic          active;
    logic          bitEnd;

    assign bitEnd = active && (baudCnt == CW'(BIT_CYCLES - 1));
    assign oDone  = bitEnd && (bitIdx == 4'd8);
    assign oTx    = shReg[0];
    assign oBusy  = active;

    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            shReg   <= '1;
            baudCnt <= '0;
            bitIdx  <= '0;
            active  <= 1'b0;
        end else if (iAbort) begin
            shReg   <= '1;
            baudCnt <= '0;
            bitIdx  <= '0;
            active  <= 1'b0;
        end else if (iStart && (!active || oDone)) begin
            shReg   <= {1'b1, iData, 1'b0};
            baudCnt <= '0;
            bitIdx  <= '0;
            active  <= 1'b1;
        end else if (bitEnd) begin
            // Shift in ones so the line idles high once the stop bit is out.
            shReg   <= {1'b1, shReg[8:1]};
            baudCnt <= '0;
            bitIdx  <= bitIdx + 4'd1;
            if (bitIdx == 4'd8) begin
                active <= 1'b0;
            end
        end else if (active) begin
            baudCnt <= baudCnt + 1'b1;
        end
    end

endmodule

// File: rtl/serial_mouse_tx.sv
// serial_mouse_tx
// Device end of a Microsoft serial-mouse link. Accumulates relative motion
// and buttons, sends 3-byte MS packets on a 7N1 line, and answers an RTS
// rising edge with the ident sequence.
// Ports:
//   iClk        system clock (CLK_FREQ Hz)
//   iRstN       asynchronous active-low reset, deassertion synchronised here
//   iMoveValid  one-cycle strobe qualifying iDx/iDy/iBtnL/iBtnR/iBtnM
//   iDx, iDy    9-bit signed deltas (+right, +down)
//   iBtnL/R/M   buttons, 1 = pressed (M only with SERIAL_MOUSE_3BTN_EN)
//   iRts        host RTS; 0 = mouse unpowered
//   oTx         serial line to host, idle 1
//   oBusy       frame or ident in flight
//   oState      current FSM state (ST_* encodings), for observation
// Handshake: iMoveValid has no ready; every strobe is taken in the cycle it
// is high (ignored only while the FSM is OFF).
// Option macro: SERIAL_MOUSE_3BTN_EN selects Logitech 3-button mode
// (ident 'M','3'; 4th byte on middle-button change).
module serial_mouse_tx
    import serial_mouse_tx_pkg::*;
#(
    parameter int CLK_FREQ  = 10_000_000,
    parameter int BAUD      = 1200,
    parameter int IDENT_DLY = CLK_FREQ / 100
) (
    input  logic       iClk,
    input  logic       iRstN,
    input  logic       iMoveValid,
    input  logic [8:0] iDx,
    input  logic [8:0] iDy,
    input  logic       iBtnL,
    input  logic       iBtnR,
    input  logic       iBtnM,
    input  logic       iRts,
    output logic       oTx,
    output logic       oBusy,
    output logic [1:0] oState
);

    localparam int BIT_CYCLES = CLK_FREQ / BAUD;
    localparam int IW         = $clog2(IDENT_DLY + 1);

    // Async assert, two-flop synchronised release.
    logic [1:0] rstSync;
    logic       rstN;

    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            rstSync <= 2'b00;
        end else begin
            rstSync <= {rstSync[0], 1'b1};
        end
    end
    assign rstN = rstSync[1];

    logic [1:0]        state;
    logic              rtsQ;
    logic [IW-1:0]     identCnt;
    logic signed [7:0] accX;
    logic signed [7:0] accY;
    logic              btnL;
    logic              btnR;
    logic              sentL;
    logic              sentR;
    logic [6:0]        byteQ [MAX_BYTES];
    logic [2:0]        nBytes;
    logic [2:0]        byteIdx;

    logic rtsRise;
    logic mChg;
    logic btnChg;
    logic pktLatch;
    logic identDone;
    logic shStart;
    logic shDone;
    logic shBusy;
    logic sendDone;

`ifdef SERIAL_MOUSE_3BTN_EN
    logic btnM;
    logic sentM;
    assign mChg = (btnM != sentM);
`else
    logic unusedBtnM;
    assign unusedBtnM = iBtnM;
    assign mChg       = 1'b0;
`endif

    assign rtsRise   = iRts && !rtsQ;
    assign btnChg    = (btnL != sentL) || (btnR != sentR) || mChg;
    assign pktLatch  = (state == ST_IDLE) &&
                       ((accX != 8'sd0) || (accY != 8'sd0) || btnChg);
    assign identDone = (state == ST_IDENT_WAIT) && (identCnt == IW'(IDENT_DLY - 1));
    // Next byte goes out as soon as the shifter is free or finishing, so
    // queued bytes run back-to-back.
    assign shStart   = (state == ST_SEND) && (!shBusy || shDone) && (byteIdx < nBytes);
    assign sendDone  = (state == ST_SEND) && shDone && (byteIdx == nBytes);

    assign oBusy  = (state == ST_SEND);
    assign oState = state;

    always_ff @(posedge iClk or negedge rstN) begin
        if (!rstN) begin
            state    <= ST_OFF;
            rtsQ     <= 1'b0;
            identCnt <= '0;
            nBytes   <= '0;
            byteIdx  <= '0;
            sentL    <= 1'b0;
            sentR    <= 1'b0;
`ifdef SERIAL_MOUSE_3BTN_EN
            sentM    <= 1'b0;
`endif
            for (int i = 0; i < MAX_BYTES; i++) begin
                byteQ[i] <= '0;
            end
        end else begin
            rtsQ     <= iRts;
            identCnt <= (state == ST_IDENT_WAIT) ? identCnt + 1'b1 : '0;
            if (shStart) begin
                byteIdx <= byteIdx + 3'd1;
            end
            // Power loss wins over everything, from any state.
            if (!iRts) begin
                state <= ST_OFF;
            end else begin
                case (state)
                    ST_OFF: begin
                        if (rtsRise) begin
                            state <= ST_IDENT_WAIT;
                        end
                    end
                    ST_IDENT_WAIT: begin
                        if (identDone) begin
                            state    <= ST_SEND;
                            byteIdx  <= '0;
                            byteQ[0] <= IDENT_M;
`ifdef SERIAL_MOUSE_3BTN_EN
                            byteQ[1] <= IDENT_3;
                            nBytes   <= 3'd2;
`else
                            nBytes   <= 3'd1;
`endif
                        end
                    end
                    ST_IDLE: begin
                        if (pktLatch) begin
                            state    <= ST_SEND;
                            byteIdx  <= '0;
                            byteQ[0] <= headerByte(btnL, btnR, accY[7:6], accX[7:6]);
                            byteQ[1] <= {1'b0, accX[5:0]};
                            byteQ[2] <= {1'b0, accY[5:0]};
                            sentL    <= btnL;
                            sentR    <= btnR;
`ifdef SERIAL_MOUSE_3BTN_EN
                            sentM    <= btnM;
                            if (mChg) begin
                                byteQ[3] <= btnM ? BYTE_M_DOWN : BYTE_M_UP;
                                nBytes   <= 3'd4;
                            end else begin
                                nBytes   <= 3'd3;
                            end
`else
                            nBytes   <= 3'd3;
`endif
                        end
                    end
                    ST_SEND: begin
                        if (sendDone) begin
                            state <= ST_IDLE;
                        end
                    end
                    default: state <= ST_OFF;
                endcase
            end
        end
    end

    // Accumulators and latched buttons. On the latch cycle the accumulators
    // restart from zero, but a move strobed in that same cycle is kept.
    always_ff @(posedge iClk or negedge rstN) begin
        if (!rstN) begin
            accX <= 8'sd0;
            accY <= 8'sd0;
            btnL <= 1'b0;
            btnR <= 1'b0;
`ifdef SERIAL_MOUSE_3BTN_EN
            btnM <= 1'b0;
`endif
        end else if (state == ST_OFF) begin
            accX <= 8'sd0;
            accY <= 8'sd0;
        end else begin
            if (pktLatch) begin
                accX <= iMoveValid ? satAdd(8'sd0, iDx) : 8'sd0;
                accY <= iMoveValid ? satAdd(8'sd0, iDy) : 8'sd0;
            end else if (iMoveValid) begin
                accX <= satAdd(accX, iDx);
                accY <= satAdd(accY, iDy);
            end
            if (iMoveValid) begin
                btnL <= iBtnL;
                btnR <= iBtnR;
`ifdef SERIAL_MOUSE_3BTN_EN
                btnM <= iBtnM;
`endif
            end
        end
    end

    serial_mouse_tx_shifter #(
        .BIT_CYCLES(BIT_CYCLES)
    ) uShifter (
        .iClk  (iClk),
        .iRstN (rstN),
        .iAbort(!iRts),
        .iStart(shStart),
        .iData (byteQ[byteIdx[1:0]]),
        .oTx   (oTx),
        .oDone (shDone),
        .oBusy (shBusy)
    );

endmodule

// File: tb/tb_serial_mouse_tx.sv
// tb_serial_mouse_tx
// Bench for serial_mouse_tx with a scaled clock (12 kHz, 1200 baud ->
// 10 clocks per bit, ident delay 120 clocks). A line receiver decodes oTx
// into bytes; a packet model built from the mouse protocol rules predicts
// the bytes. Honours SERIAL_MOUSE_3BTN_EN like the design.
module tb_serial_mouse_tx;

    localparam int CLK_FREQ  = 12000;
    localparam int BAUD      = 1200;
    localparam int BIT       = CLK_FREQ / BAUD;
    localparam int IDENT_DLY = CLK_FREQ / 100;

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       rst_n;
    logic       move_valid;
    logic [8:0] dx_in;
    logic [8:0] dy_in;
    logic       btn_l;
    logic       btn_r;
    logic       btn_m;
    logic       rts;
    logic       tx;
    logic       busy;
    logic [1:0] state;
    int         cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    serial_mouse_tx #(
        .CLK_FREQ(CLK_FREQ),
        .BAUD    (BAUD)
    ) dut (
        .iClk      (clk),
        .iRstN     (rst_n),
        .iMoveValid(move_valid),
        .iDx       (dx_in),
        .iDy       (dy_in),
        .iBtnL     (btn_l),
        .iBtnR     (btn_r),
        .iBtnM     (btn_m),
        .iRts      (rts),
        .oTx       (tx),
        .oBusy     (busy),
        .oState    (state)
    );

    // ---------------- scoreboard state ----------------
    int         n_checks = 0;
    int         n_fail   = 0;
    logic [6:0] exp_q[$];
    logic [6:0] rx_q[$];
    int         rx_t[$];
    logic       rx_stop[$];
    logic       rx_busy[$];

    // Behavioural model: accumulated motion, current and last-sent buttons.
    int   mx, my;
    logic ml, mr, mm, sl, sr, sm;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- line receiver ----------------
    initial begin : rx_monitor
        logic [6:0] d;
        int         t0;
        logic       bs;
        forever begin
            @(negedge tx);
            repeat (BIT / 2) @(negedge clk);
            t0 = cyc;
            bs = busy;
            if (tx == 1'b0) begin
                for (int i = 0; i < 7; i++) begin
                    repeat (BIT) @(negedge clk);
                    d[i] = tx;
                end
                repeat (BIT) @(negedge clk);
                rx_q.push_back(d);
                rx_t.push_back(t0);
                rx_stop.push_back(tx);
                rx_busy.push_back(bs);
            end
        end
    end

    initial begin : watchdog
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- model ----------------
    function automatic int sat(input int v);
        if (v > 127) return 127;
        if (v < -128) return -128;
        return v;
    endfunction

    task automatic model_move(input int dx, input int dy, input logic l, input logic r, input logic m);
        mx = sat(mx + dx);
        my = sat(my + dy);
        ml = l;
        mr = r;
        mm = m;
    endtask

    // Packet the device should emit at a latch point; returns byte count.
    function automatic int model_latch();
        logic [31:0] ux, uy;
        logic        mchg;
        mchg = 1'b0;
`ifdef SERIAL_MOUSE_3BTN_EN
        mchg = (mm != sm);
`endif
        if (mx == 0 && my == 0 && ml == sl && mr == sr && !mchg) return 0;
        ux = mx;
        uy = my;
        exp_q.push_back({1'b1, ml, mr, uy[7:6], ux[7:6]});
        exp_q.push_back({1'b0, ux[5:0]});
        exp_q.push_back({1'b0, uy[5:0]});
        if (mchg) exp_q.push_back(mm ? 7'h20 : 7'h00);
        sl = ml;
        sr = mr;
        sm = mm;
        mx = 0;
        my = 0;
        return mchg ? 4 : 3;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_move(input int dx, input int dy, input logic l, input logic r, input logic m);
        logic [31:0] ux, uy;
        ux = dx;
        uy = dy;
        dx_in      = ux[8:0];
        dy_in      = uy[8:0];
        btn_l      = l;
        btn_r      = r;
        btn_m      = m;
        move_valid = 1'b1;
        @(negedge clk);
        move_valid = 1'b0;
    endtask

    task automatic flush_rx();
        rx_q.delete();
        rx_t.delete();
        rx_stop.delete();
        rx_busy.delete();
    endtask

    task automatic expect_packet(input int n, input string tag);
        int         waited;
        int         prev_t;
        logic [6:0] e;
        waited = 0;
        while (rx_q.size() < n && waited < n * 9 * BIT + 400) begin
            @(negedge clk);
            waited++;
        end
        check({tag, " bytes arrived"}, rx_q.size() >= n, 1'b1);
        if (rx_q.size() < n) begin
            exp_q.delete();
            return;
        end
        prev_t = 0;
        for (int i = 0; i < n; i++) begin
            e = exp_q.pop_front();
            check($sformatf("%s b%0d", tag, i), rx_q[0], e);
            check($sformatf("%s stop%0d", tag, i), rx_stop[0], 1'b1);
            check($sformatf("%s busy%0d", tag, i), rx_busy[0], 1'b1);
            if (i > 0) check($sformatf("%s gap%0d", tag, i), rx_t[0] - prev_t, 9 * BIT);
            prev_t = rx_t[0];
            void'(rx_q.pop_front());
            void'(rx_t.pop_front());
            void'(rx_stop.pop_front());
            void'(rx_busy.pop_front());
        end
        if (waited > 0) begin
            waited = 0;
            while (busy && waited < 3 * BIT) begin
                @(negedge clk);
                waited++;
            end
            check({tag, " busy release"}, (waited >= BIT / 2 - 3) && (waited <= BIT / 2 + 3), 1'b1);
        end
    endtask

    task automatic expect_silence(input int cycles, input string tag);
        int lows;
        lows = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (tx !== 1'b1) lows++;
        end
        check({tag, " line low cycles"}, lows, 0);
        check({tag, " bytes"}, rx_q.size(), 0);
    endtask

    task automatic raise_ident(input string tag);
        int k;
        int n;
        rts = 1'b1;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (tx === 1'b1 && k < IDENT_DLY + 50);
        check({tag, " delay"}, (k >= IDENT_DLY) && (k <= IDENT_DLY + 3), 1'b1);
        exp_q.push_back(7'h4D);
        n = 1;
`ifdef SERIAL_MOUSE_3BTN_EN
        exp_q.push_back(7'h33);
        n = 2;
`endif
        expect_packet(n, tag);
        tick(2);
        check({tag, " state idle"}, state, 2'd2);
    endtask

    task automatic wait_busy(input string tag);
        int w;
        w = 0;
        while (!busy && w < 10) begin
            @(negedge clk);
            w++;
        end
        check({tag, " busy rise"}, busy, 1'b1);
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin : main
        int n1, n2, nb, d, dy;
        rst_n = 1'b0; rts = 1'b0; move_valid = 1'b0;
        dx_in = '0; dy_in = '0; btn_l = 1'b0; btn_r = 1'b0; btn_m = 1'b0;
        mx = 0; my = 0; ml = 0; mr = 0; mm = 0; sl = 0; sr = 0; sm = 0;

        tick(3);
        check("reset tx", tx, 1'b1);
        check("reset busy", busy, 1'b0);
        check("reset state", state, 2'd0);
        rst_n = 1'b1;
        tick(5);
        check("post-reset state", state, 2'd0);

        // Moves while unpowered are dropped.
        do_move(10, -10, 1'b1, 1'b1, 1'b1);
        do_move(0, 0, 1'b0, 1'b0, 1'b0);
        expect_silence(5 * BIT, "off");

        raise_ident("ident1");

        // Basic packet.
        do_move(5, -3, 1'b1, 1'b0, 1'b0);
        model_move(5, -3, 1'b1, 1'b0, 1'b0);
        n1 = model_latch();
        wait_busy("pkt1");
        // Two moves during SEND saturate into the next packet.
        do_move(100, 0, 1'b1, 1'b0, 1'b0);
        model_move(100, 0, 1'b1, 1'b0, 1'b0);
        do_move(100, 0, 1'b1, 1'b0, 1'b0);
        model_move(100, 0, 1'b1, 1'b0, 1'b0);
        expect_packet(n1, "pkt1");
        n2 = model_latch();
        expect_packet(n2, "pkt_sat");
        tick(3);

        // Second move lands exactly on the latch cycle.
        do_move(-7, 9, 1'b0, 1'b1, 1'b0);
        model_move(-7, 9, 1'b0, 1'b1, 1'b0);
        n1 = model_latch();
        do_move(12, -20, 1'b0, 1'b1, 1'b0);
        model_move(12, -20, 1'b0, 1'b1, 1'b0);
        expect_packet(n1, "latchA");
        n2 = model_latch();
        expect_packet(n2, "latchB");
        tick(3);

        // RTS drop in the middle of byte 1.
        do_move(33, 44, 1'b0, 1'b0, 1'b0);
        model_move(33, 44, 1'b0, 1'b0, 1'b0);
        n1 = model_latch();
        n2 = 0;
        while (rx_q.size() < 1 && n2 < 20 * BIT) begin
            @(negedge clk);
            n2++;
        end
        check("drop b0 seen", rx_q.size(), 1);
        tick(3 * BIT);
        rts = 1'b0;
        @(negedge clk);
        check("drop tx high", tx, 1'b1);
        check("drop state off", state, 2'd0);
        check("drop busy low", busy, 1'b0);
        tick(10 * BIT);
        flush_rx();
        exp_q.delete();
        expect_silence(20 * BIT, "dropped");
        raise_ident("ident2");

        // Middle button alone.
        do_move(0, 0, ml, mr, 1'b1);
        model_move(0, 0, ml, mr, 1'b1);
        n1 = model_latch();
        if (n1 > 0) expect_packet(n1, "btn_m");
        else expect_silence(40 * BIT, "btn_m");
        tick(3);

        // Randomised packets.
        for (int it = 0; it < 6; it++) begin
            d  = $urandom_range(1, 255);
            if ($urandom_range(0, 1) == 1) d = -d;
            dy = int'($urandom_range(0, 511)) - 256;
            do_move(d, dy, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            model_move(d, dy, btn_l, btn_r, btn_m);
            n1 = model_latch();
            wait_busy($sformatf("rnd%0d", it));
            nb = $urandom_range(0, 3);
            for (int j = 0; j < nb; j++) begin
                d  = int'($urandom_range(0, 511)) - 256;
                dy = int'($urandom_range(0, 511)) - 256;
                do_move(d, dy, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                model_move(d, dy, btn_l, btn_r, btn_m);
            end
            expect_packet(n1, $sformatf("rnd%0d a", it));
            n2 = model_latch();
            if (n2 > 0) expect_packet(n2, $sformatf("rnd%0d b", it));
            else expect_silence(3 * BIT, $sformatf("rnd%0d b", it));
            tick(3);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
